// File: rtl/coherence_bus_ctrl.sv
// Bus/coherence controller: round-robin arbitration of CPUS icache/dcache pairs onto
// one single-ported RAM, with snoop broadcast and cache-to-cache transfer from an M owner.
module coherence_bus_ctrl #(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  input  logic [CPUS-1:0]          cctrans,
  input  logic [CPUS-1:0]          ccwrite,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic [CPUS-1:0]          ccwait,
  output logic [CPUS-1:0]          ccinv,
  output logic [CPUS*WORD_W-1:0]   ccsnoopaddr,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic                     ram_wait
);

  localparam int unsigned IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic [2:0] {IDLE, SNOOP, C2C, MEMRD, MEMWR, IFETCH} state_e;

  state_e state_q, state_d;
  idx_t   req_q, req_d, snp_q, snp_d;
  idx_t   d_ptr_q, d_ptr_d, i_ptr_q, i_ptr_d;

  logic [CPUS-1:0] iwait_q, iwait_d, dwait_q, dwait_d;
  logic [CPUS-1:0] ccwait_q, ccwait_d, ccinv_q, ccinv_d;
  word_t           iload_q [CPUS];
  word_t           iload_d [CPUS];
  word_t           dload_q [CPUS];
  word_t           dload_d [CPUS];
  word_t           csa_q   [CPUS];
  word_t           csa_d   [CPUS];
  logic            ram_ren_q, ram_ren_d, ram_wen_q, ram_wen_d;
  word_t           ramaddr_q, ramaddr_d, ramstore_q, ramstore_d;

  word_t iaddr_a  [CPUS];
  word_t daddr_a  [CPUS];
  word_t dstore_a [CPUS];

  // Per-CPU views of the flattened buses
  for (genvar g = 0; g < CPUS; g++) begin : g_cpu
    assign iaddr_a[g]  = iaddr[g*WORD_W +: WORD_W];
    assign daddr_a[g]  = daddr[g*WORD_W +: WORD_W];
    assign dstore_a[g] = dstore[g*WORD_W +: WORD_W];
    assign iload[g*WORD_W +: WORD_W]       = iload_q[g];
    assign dload[g*WORD_W +: WORD_W]       = dload_q[g];
    assign ccsnoopaddr[g*WORD_W +: WORD_W] = csa_q[g];
  end

  assign iwait    = iwait_q;
  assign dwait    = dwait_q;
  assign ccwait   = ccwait_q;
  assign ccinv    = ccinv_q;
  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;

  // First set bit of v at or after ptr, wrapping at CPUS
  function automatic idx_t rr_pick(input logic [CPUS-1:0] v, input idx_t ptr);
    logic [2*CPUS-1:0] dbl;
    logic [CPUS-1:0]   rot;
    idx_t              res;
    dbl = {v, v} >> ptr;
    rot = dbl[CPUS-1:0];
    res = ptr;
    for (int k = CPUS - 1; k >= 0; k--) begin
      if (rot[k]) res = idx_t'((32'(ptr) + 32'(k)) % CPUS);
    end
    return res;
  endfunction

  function automatic idx_t ptr_inc(input idx_t p);
    return (32'(p) == CPUS - 1) ? '0 : p + idx_t'(1);
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    logic [CPUS-1:0] dwen_m, dren_m, iren_m, others;
    idx_t            pick, snp_sel;
    logic            snp_found;

    state_d    = state_q;
    req_d      = req_q;
    snp_d      = snp_q;
    d_ptr_d    = d_ptr_q;
    i_ptr_d    = i_ptr_q;
    iwait_d    = '1;
    dwait_d    = '1;
    iload_d    = iload_q;
    dload_d    = dload_q;
    ccwait_d   = ccwait_q;
    ccinv_d    = ccinv_q;
    csa_d      = csa_q;
    ram_ren_d  = ram_ren_q;
    ram_wen_d  = ram_wen_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    pick       = '0;
    snp_sel    = '0;
    snp_found  = 1'b0;
    others     = '0;

    // A cache seeing its wait low this cycle still shows the finished request
    dwen_m = dWEN & dwait_q;
    dren_m = dREN & dwait_q;
    iren_m = iREN & iwait_q;

    unique case (state_q)
      IDLE: begin
        if (|dwen_m) begin
          pick       = rr_pick(dwen_m, d_ptr_q);
          req_d      = pick;
          state_d    = MEMWR;
          ram_wen_d  = 1'b1;
          ramaddr_d  = daddr_a[pick];
          ramstore_d = dstore_a[pick];
        end else if (|dren_m) begin
          pick  = rr_pick(dren_m, d_ptr_q);
          req_d = pick;
          if (cctrans[pick]) begin
            others   = ~(CPUS'(1) << pick);
            state_d  = SNOOP;
            ccwait_d = others;
            ccinv_d  = ccwrite[pick] ? others : '0;
            for (int j = 0; j < CPUS; j++) begin
              if (j != int'(pick)) csa_d[j] = daddr_a[pick];
            end
          end else begin
            state_d   = MEMRD;
            ram_ren_d = 1'b1;
            ramaddr_d = daddr_a[pick];
          end
        end else if (|iren_m) begin
          pick      = rr_pick(iren_m, i_ptr_q);
          req_d     = pick;
          state_d   = IFETCH;
          ram_ren_d = 1'b1;
          ramaddr_d = iaddr_a[pick];
        end
      end

      SNOOP: begin
        // Lowest-numbered snooper writing back is the M owner
        for (int j = CPUS - 1; j >= 0; j--) begin
          if (dWEN[j] && (j != int'(req_q))) begin
            snp_found = 1'b1;
            snp_sel   = idx_t'(j);
          end
        end
        ramaddr_d = daddr_a[req_q];
        if (snp_found) begin
          snp_d      = snp_sel;
          state_d    = C2C;
          ram_wen_d  = 1'b1;
          ramstore_d = dstore_a[snp_sel];
        end else begin
          state_d   = MEMRD;
          ram_ren_d = 1'b1;
        end
      end

      C2C: begin
        ramstore_d = dstore_a[snp_q];
        if (!ram_wait) begin
          dload_d[req_q] = dstore_a[snp_q];
          dwait_d[req_q] = 1'b0;
          dwait_d[snp_q] = 1'b0;
          ram_wen_d      = 1'b0;
          ccwait_d       = '0;
          ccinv_d        = '0;
          d_ptr_d        = ptr_inc(req_q);
          state_d        = IDLE;
        end
      end

      MEMRD: begin
        if (!ram_wait) begin
          dload_d[req_q] = ramload;
          dwait_d[req_q] = 1'b0;
          ram_ren_d      = 1'b0;
          ccwait_d       = '0;
          ccinv_d        = '0;
          d_ptr_d        = ptr_inc(req_q);
          state_d        = IDLE;
        end
      end

      MEMWR: begin
        if (!ram_wait) begin
          dwait_d[req_q] = 1'b0;
          ram_wen_d      = 1'b0;
          d_ptr_d        = ptr_inc(req_q);
          state_d        = IDLE;
        end
      end

      IFETCH: begin
        if (!ram_wait) begin
          iload_d[req_q] = ramload;
          iwait_d[req_q] = 1'b0;
          ram_ren_d      = 1'b0;
          i_ptr_d        = ptr_inc(req_q);
          state_d        = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      req_q      <= '0;
      snp_q      <= '0;
      d_ptr_q    <= '0;
      i_ptr_q    <= '0;
      iwait_q    <= '1;
      dwait_q    <= '1;
      ccwait_q   <= '0;
      ccinv_q    <= '0;
      ram_ren_q  <= 1'b0;
      ram_wen_q  <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      for (int j = 0; j < CPUS; j++) begin
        iload_q[j] <= '0;
        dload_q[j] <= '0;
        csa_q[j]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      snp_q      <= snp_d;
      d_ptr_q    <= d_ptr_d;
      i_ptr_q    <= i_ptr_d;
      iwait_q    <= iwait_d;
      dwait_q    <= dwait_d;
      ccwait_q   <= ccwait_d;
      ccinv_q    <= ccinv_d;
      ram_ren_q  <= ram_ren_d;
      ram_wen_q  <= ram_wen_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
      csa_q      <= csa_d;
    end
  end

endmodule
